// File: rtl/aes_compare.sv
// Lockstep ciphertext comparator: buffers two AES output streams in
// independent FIFOs, compares heads pairwise and keeps match statistics
// plus sticky overflow / skew-timeout error flags.
module aes_compare #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         a_valid,
    input  logic [127:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [127:0] b_data,
    output logic         b_ready,
    output logic         cmp_valid,
    output logic         cmp_match,
    output logic [31:0]  match_count,
    output logic [31:0]  mismatch_count,
    output logic [31:0]  first_bad_index,
    output logic         error,
    output logic         overflow,
    output logic         timeout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [31:0]   WD_MAX = 32'(TIMEOUT);

    logic [127:0]  a_mem [DEPTH];
    logic [127:0]  b_mem [DEPTH];
    logic [AW-1:0] a_wr, a_rd, b_wr, b_rd;
    logic [CW-1:0] a_cnt, b_cnt;
    logic [31:0]   pair_count;
    logic [31:0]   wd, wd_next;

    logic a_push, b_push, pop, heads_equal, one_busy;
    logic a_drop, b_drop;

    // Readiness is purely from registered occupancy, so a same-cycle pop
    // never frees room for a push into a full FIFO.
    assign a_ready     = (a_cnt != FULL);
    assign b_ready     = (b_cnt != FULL);
    assign a_push      = a_valid && a_ready;
    assign b_push      = b_valid && b_ready;
    assign a_drop      = a_valid && !a_ready;
    assign b_drop      = b_valid && !b_ready;
    assign pop         = (a_cnt != '0) && (b_cnt != '0);
    assign heads_equal = (a_mem[a_rd] == b_mem[b_rd]);
    assign one_busy    = (a_cnt != '0) ^ (b_cnt != '0);

    // Skew watchdog: counts while only one side holds data, parks at the limit.
    always_comb begin
        wd_next = '0;
        if (one_busy) begin
            wd_next = (wd == WD_MAX) ? wd : wd + 32'd1;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clock) begin
        if (!reset && a_push) a_mem[a_wr] <= a_data;
        if (!reset && b_push) b_mem[b_wr] <= b_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_wr  <= '0;
            a_rd  <= '0;
            a_cnt <= '0;
            b_wr  <= '0;
            b_rd  <= '0;
            b_cnt <= '0;
        end else begin
            if (a_push) a_wr <= a_wr + 1'b1;
            if (b_push) b_wr <= b_wr + 1'b1;
            if (pop) begin
                a_rd <= a_rd + 1'b1;
                b_rd <= b_rd + 1'b1;
            end
            a_cnt <= a_cnt + CW'(a_push) - CW'(pop);
            b_cnt <= b_cnt + CW'(b_push) - CW'(pop);
        end
    end

    // Comparison result, statistics and sticky flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmp_valid       <= 1'b0;
            cmp_match       <= 1'b0;
            match_count     <= '0;
            mismatch_count  <= '0;
            first_bad_index <= '1;
            pair_count      <= '0;
            error           <= 1'b0;
            overflow        <= 1'b0;
            timeout         <= 1'b0;
            wd              <= '0;
        end else begin
            cmp_valid <= pop;
            cmp_match <= pop && heads_equal;
            wd        <= wd_next;
            if (pop) begin
                pair_count <= pair_count + 32'd1;
                if (heads_equal) begin
                    if (match_count != '1) match_count <= match_count + 32'd1;
                end else begin
                    if (mismatch_count == '0) first_bad_index <= pair_count;
                    if (mismatch_count != '1) mismatch_count <= mismatch_count + 32'd1;
                end
            end
            if (a_drop || b_drop) overflow <= 1'b1;
            if (one_busy && wd_next == WD_MAX) timeout <= 1'b1;
            if (a_drop || b_drop || (pop && !heads_equal) || (one_busy && wd_next == WD_MAX))
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_compare.sv
// Randomized bench for aes_compare with a queue-based reference model.
module tb_aes_compare;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         a_valid = 1'b0, b_valid = 1'b0;
    logic [127:0] a_data = '0, b_data = '0;
    logic         a_ready, b_ready, cmp_valid, cmp_match;
    logic [31:0]  match_count, mismatch_count, first_bad_index;
    logic         error, overflow, timeout;

    aes_compare #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .cmp_valid(cmp_valid), .cmp_match(cmp_match),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .first_bad_index(first_bad_index),
        .error(error), .overflow(overflow), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    // reference model state (value visible after the most recent edge)
    logic [127:0] aq[$], bq[$];
    bit          m_cv, m_cm, m_err, m_ovf, m_to, m_bad_seen;
    logic [31:0] m_mc, m_mmc, m_fbi, m_pairs;
    int          m_wd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // One clock: check outputs left by the previous edge, drive new inputs,
    // advance the model by the edge that is about to happen.
    task automatic step(input bit rst, input bit av, input logic [127:0] ad,
                        input bit bv, input logic [127:0] bd);
        int na, nb;
        logic [127:0] x, y;
        @(negedge clock);
        if (chk_en) begin
            check("a_ready", 32'(a_ready), 32'(aq.size() < DEPTH));
            check("b_ready", 32'(b_ready), 32'(bq.size() < DEPTH));
            check("cmp_valid", 32'(cmp_valid), 32'(m_cv));
            if (m_cv) check("cmp_match", 32'(cmp_match), 32'(m_cm));
            check("match_count", match_count, m_mc);
            check("mismatch_count", mismatch_count, m_mmc);
            check("first_bad_index", first_bad_index, m_fbi);
            check("error", 32'(error), 32'(m_err));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("timeout", 32'(timeout), 32'(m_to));
        end
        reset = rst; a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
        if (rst) begin
            aq.delete(); bq.delete();
            m_cv = 0; m_cm = 0; m_err = 0; m_ovf = 0; m_to = 0; m_bad_seen = 0;
            m_mc = 0; m_mmc = 0; m_fbi = 32'hFFFF_FFFF; m_pairs = 0; m_wd = 0;
        end else begin
            na = aq.size(); nb = bq.size();
            m_cv = (na > 0) && (nb > 0);
            m_cm = 0;
            if (m_cv) begin
                x = aq.pop_front(); y = bq.pop_front();
                m_cm = (x == y);
                if (m_cm) m_mc = sat_inc(m_mc);
                else begin
                    if (!m_bad_seen) m_fbi = m_pairs;
                    m_bad_seen = 1;
                    m_mmc = sat_inc(m_mmc);
                    m_err = 1;
                end
                m_pairs = m_pairs + 32'd1;
            end
            if (av) begin
                if (na < DEPTH) aq.push_back(ad);
                else begin m_ovf = 1; m_err = 1; end
            end
            if (bv) begin
                if (nb < DEPTH) bq.push_back(bd);
                else begin m_ovf = 1; m_err = 1; end
            end
            if ((na > 0) != (nb > 0)) begin
                if (m_wd < TIMEOUT) m_wd++;
                if (m_wd == TIMEOUT) begin m_to = 1; m_err = 1; end
            end else m_wd = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0);
    endtask

    logic [127:0] w[3];
    logic [127:0] pool[16];

    initial begin
        int ai, bi, pa, pb;
        logic [127:0] bw;
        step(1, 0, '0, 0, '0);
        chk_en = 1;
        step(1, 0, '0, 0, '0);
        step(1, 1, rand128(), 1, rand128());   // inputs during reset are ignored

        // single matching pair
        step(0, 1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        idle(1);
        @(posedge clock); #1;
        check("dir_single_valid", 32'(cmp_valid), 32'd1);
        check("dir_single_match", 32'(cmp_match), 32'd1);
        check("dir_single_count", match_count, 32'd1);
        idle(2);

        // A leads B by five cycles; one B word has bit 0 flipped
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < 3; i++) w[i] = rand128();
        for (int i = 0; i < 3; i++) step(0, 1, w[i], 0, '0);
        idle(2);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, (i == 1) ? (w[i] ^ 128'd1) : w[i]);
        idle(4);
        check("dir_skew_fbi", first_bad_index, 32'd1);
        check("dir_skew_timeout", 32'(timeout), 32'd0);

        // overflow: five back-to-back pushes into A with B idle
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 1, rand128(), 0, '0);
        idle(1);
        check("dir_ovf_ready", 32'(a_ready), 32'd0);

        // timeout then reset
        step(1, 0, '0, 0, '0);
        step(0, 1, rand128(), 0, '0);
        idle(TIMEOUT + 3);
        step(1, 0, '0, 0, '0);
        idle(2);

        // randomized phases with varying stream activity
        for (int i = 0; i < 16; i++) pool[i] = rand128();
        for (int ph = 0; ph < 12; ph++) begin
            pa = $urandom_range(20, 100);
            pb = (ph % 4 == 3) ? 0 : $urandom_range(20, 100);
            ai = 0; bi = 0;
            step(1, 0, '0, 0, '0);
            for (int c = 0; c < 150; c++) begin
                bit av, bv;
                av = ($urandom_range(99) < pa);
                bv = ($urandom_range(99) < pb);
                bw = pool[bi % 16];
                if ($urandom_range(9) == 0) bw[$urandom_range(127)] ^= 1'b1;
                step(($urandom_range(199) == 0), av, pool[ai % 16], bv, bw);
                if (av) ai++;
                if (bv) bi++;
            end
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_compare.md
AES_COMPARE -- requirements
Module: aes_compare

Interface
REQ-001 Parameter DEPTH, default 4: entries per input FIFO; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 64: max cycles one FIFO may hold data while the other is empty.
REQ-003 Port clock  input  1  rising-edge clock.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port a_valid  input  1  stream A ciphertext present this cycle.
REQ-006 Port a_data  input  128  stream A ciphertext (reticle core).
REQ-007 Port a_ready  output  1  FIFO A not full; combinational from registered state.
REQ-008 Port b_valid  input  1  stream B ciphertext present this cycle.
REQ-009 Port b_data  input  128  stream B ciphertext (reference core).
REQ-010 Port b_ready  output  1  FIFO B not full.
REQ-011 Port cmp_valid  output  1  one-cycle pulse: a comparison completed.
REQ-012 Port cmp_match  output  1  result of that comparison; meaningful only when cmp_valid=1.
REQ-013 Port match_count  output  32  total matching pairs.
REQ-014 Port mismatch_count  output  32  total mismatching pairs.
REQ-015 Port first_bad_index  output  32  0-based pair index of first mismatch.
REQ-016 Port error  output  1  sticky: any mismatch, overflow or timeout.
REQ-017 Port overflow  output  1  sticky: valid asserted while ready low on either stream.
REQ-018 Port timeout  output  1  sticky: skew watchdog expired.

Function
REQ-019 Each stream SHALL have an independent DEPTH-entry FIFO of 128-bit words; push when x_valid && x_ready.
REQ-020 x_ready SHALL equal not-full of FIFO x; a full FIFO SHALL NOT accept a push even if a pop occurs the same cycle.
REQ-021 Word pushed in cycle N SHALL be poppable no earlier than cycle N+1 (no fall-through).
REQ-022 When both FIFOs non-empty in cycle N, both heads SHALL pop in cycle N and be compared bitwise over all 128 bits.
REQ-023 cmp_valid and cmp_match SHALL be registered: asserted in cycle N+1 for a pop in cycle N; at most one comparison per cycle.
REQ-024 Counters SHALL update in the same cycle cmp_valid asserts; each saturates at 0xFFFFFFFF, never wraps.
REQ-025 Pair index = match_count + mismatch_count before the update (unsaturated internal 32-bit pair counter, wraps mod 2^32).
REQ-026 first_bad_index SHALL be captured on the first mismatch only; holds 0xFFFFFFFF until then.
REQ-027 x_valid with x_ready=0 SHALL drop the word, set overflow and error; FIFO contents unchanged.
REQ-028 Watchdog: counter increments each cycle exactly one FIFO is non-empty and no pop occurs; clears otherwise; reaching TIMEOUT sets timeout and error and stops counting.
REQ-029 Sticky flags SHALL clear only on reset; comparison continues after error.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; full/empty by an extra pointer bit or occupancy counter.

Reset
REQ-031 On reset: FIFOs empty, a_ready=b_ready=1, cmp_valid=0, cmp_match=0, counts 0, first_bad_index=0xFFFFFFFF, error=overflow=timeout=0, watchdog 0.
REQ-032 Reset mid-operation SHALL discard all buffered words; inputs sampled during reset cycles are ignored.
REQ-033 Reset SHALL take priority over push, pop and flag updates in the same cycle.

Verification
REQ-034 Both streams push 69c4e0d86a7b0430d8cdb78070b4c55a in cycle 5 -> cmp_valid=1, cmp_match=1 in cycle 7; match_count=1; error=0.
REQ-035 A pushes 3 words cycles 5-7, B pushes same words cycles 10-12 -> 3 matches, cmp_valid cycles 12-14, timeout=0 with TIMEOUT=64.
REQ-036 B word differs in bit 0 on second pair -> mismatch_count=1, first_bad_index=1, error=1, match_count keeps counting later pairs.
REQ-037 A pushes 5 words back-to-back, B idle, DEPTH=4 -> a_ready=0 after 4th push, 5th dropped, overflow=1, error=1.
REQ-038 A pushes 1 word, B idle -> timeout=1 exactly TIMEOUT cycles after word becomes poppable; then reset -> all outputs at REQ-031 values next cycle.
